// File: rtl/mole_target_ctrl.sv
// mole_target_ctrl: lights requested target LEDs, times them out, and scores switch-toggle hits and misses.
module mole_target_ctrl #(
    parameter int NUM_LEDS    = 18,
    parameter int TICK_CYCLES = 50000,
    parameter int ON_TICKS    = 1000,
    parameter int MAX_ACTIVE  = 4,
    parameter int SCORE_W     = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          led_index,
    input  logic                led_request,
    input  logic [NUM_LEDS-1:0] switches,
    output logic [NUM_LEDS-1:0] leds,
    output logic [SCORE_W-1:0]  score,
    output logic [7:0]          misses,
    output logic                req_accept,
    output logic                hit,
    output logic                miss
);
    localparam int TW  = $clog2(ON_TICKS + 1);
    localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SSW = SCORE_W + 7;
    logic [PW-1:0]       presc;
    logic [NUM_LEDS-1:0] sw_prev, edges, hits, expire, req_vec;
    logic [TW-1:0]       timer [NUM_LEDS];
    logic                tick, accept;
    logic [5:0]          n_hit, n_exp, n_act;
    logic [SSW-1:0]      score_sum;
    logic [9:0]          miss_sum;
    always_comb begin
        tick  = presc == PW'(TICK_CYCLES - 1);
        edges = switches ^ sw_prev;
        hits  = leds & edges;
        n_hit = '0;
        n_exp = '0;
        n_act = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            // a hit on the expiring tick wins, so that LED is not a miss
            expire[i]  = tick && leds[i] && timer[i] == TW'(1) && !hits[i];
            req_vec[i] = led_request && led_index == 5'(i);
            n_hit      = n_hit + 6'(hits[i]);
            n_exp      = n_exp + 6'(expire[i]);
            n_act      = n_act + 6'(leds[i]);
        end
        accept    = !rst && |(req_vec & ~leds) && n_act < 6'(MAX_ACTIVE);
        score_sum = SSW'(score) + SSW'(n_hit);
        miss_sum  = 10'(misses) + 10'(n_exp);
        req_accept = accept;
        hit        = !rst && |hits;
        miss       = !rst && |expire;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            sw_prev <= switches;
            leds    <= '0;
            score   <= '0;
            misses  <= '0;
            for (int i = 0; i < NUM_LEDS; i++) timer[i] <= '0;
        end else begin
            presc   <= tick ? '0 : presc + PW'(1);
            sw_prev <= switches;
            score   <= |score_sum[SSW-1:SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            misses  <= |miss_sum[9:8] ? 8'hFF : miss_sum[7:0];
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (hits[i] || expire[i]) begin
                    leds[i]  <= 1'b0;
                    timer[i] <= '0;
                end else if (accept && req_vec[i]) begin
                    leds[i]  <= 1'b1;
                    timer[i] <= TW'(ON_TICKS);
                end else if (tick && timer[i] != '0) begin
                    timer[i] <= timer[i] - TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mole_target_ctrl.sv
// tb_mole_target_ctrl: directed checks of requests, timeouts, hits, priority and score saturation.
module tb_mole_target_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic [4:0]  led_index = '0, led_index2 = '0;
    logic        led_request = 1'b0, led_request2 = 1'b0;
    logic [17:0] switches = 18'h3FFFF, switches2 = '0;
    logic [17:0] leds, leds2;
    logic [11:0] score;
    logic [1:0]  score2;
    logic [7:0]  misses, misses2;
    logic        req_accept, hit, miss, req_accept2, hit2, miss2;
    int n_chk = 0, n_fail = 0, cyc_n = 0;

    mole_target_ctrl #(.NUM_LEDS(18), .TICK_CYCLES(4), .ON_TICKS(3), .MAX_ACTIVE(2), .SCORE_W(12)) dut (
        .clk(clk), .rst(rst), .led_index(led_index), .led_request(led_request), .switches(switches),
        .leds(leds), .score(score), .misses(misses), .req_accept(req_accept), .hit(hit), .miss(miss));

    mole_target_ctrl #(.NUM_LEDS(18), .TICK_CYCLES(4), .ON_TICKS(3), .MAX_ACTIVE(2), .SCORE_W(2)) dut2 (
        .clk(clk), .rst(rst), .led_index(led_index2), .led_request(led_request2), .switches(switches2),
        .leds(leds2), .score(score2), .misses(misses2), .req_accept(req_accept2), .hit(hit2), .miss(miss2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
    endtask

    task automatic go(input int c);
        adv(c - cyc_n);
    endtask

    initial begin
        adv(2);
        chk("rst_leds", leds, 0);
        chk("rst_score", score, 0);
        chk("rst_misses", misses, 0);
        chk("rst_hit", hit, 0);
        chk("rst_accept", req_accept, 0);
        rst = 1'b0;
        cyc_n = 0;
        #1 chk("post_rst_hit", hit, 0);
        go(1);
        chk("idle_leds", leds, 0);
        chk("idle_score", score, 0);
        chk("idle_misses", misses, 0);
        chk("idle_hit", hit, 0);
        // timeout of LED 5: ticks fall on cycles 3, 7, 11
        go(2);
        led_index = 5; led_request = 1'b1;
        #1 chk("acc5", req_accept, 1);
        go(3);
        led_request = 1'b0;
        chk("lit5", leds, 18'h00020);
        chk("miss5_early", miss, 0);
        go(10);
        chk("lit5_late", leds, 18'h00020);
        chk("miss5_not_yet", miss, 0);
        go(11);
        chk("miss5_pulse", miss, 1);
        chk("misses_before", misses, 0);
        go(12);
        chk("cleared5", leds, 0);
        chk("miss5_done", miss, 0);
        chk("misses1", misses, 1);
        chk("score0", score, 0);
        // hit on LED 7
        led_index = 7; led_request = 1'b1;
        #1 chk("acc7", req_accept, 1);
        go(13);
        led_request = 1'b0;
        chk("lit7", leds, 18'h00080);
        go(15);
        switches[7] = ~switches[7];
        #1 chk("hit7", hit, 1);
        go(16);
        chk("cleared7", leds, 0);
        chk("score1", score, 1);
        chk("hit7_done", hit, 0);
        go(17);
        switches[7] = ~switches[7];
        #1 chk("unlit_toggle", hit, 0);
        go(18);
        chk("score1_hold", score, 1);
        chk("leds_empty", leds, 0);
        // active-count limit, duplicate and out-of-range requests
        led_index = 1; led_request = 1'b1;
        #1 chk("acc1", req_accept, 1);
        go(19);
        led_index = 2;
        #1 chk("acc2", req_accept, 1);
        go(20);
        led_index = 3;
        #1 chk("rej3_full", req_accept, 0);
        chk("leds12", leds, 18'h00006);
        go(21);
        led_index = 1;
        #1 chk("rej1_lit", req_accept, 0);
        chk("leds12_b", leds, 18'h00006);
        go(22);
        led_request = 1'b0;
        go(27);
        chk("miss1_pulse", miss, 1);
        go(28);
        chk("leds2_only", leds, 18'h00004);
        chk("misses2", misses, 2);
        led_index = 20; led_request = 1'b1;
        #1 chk("rej20", req_accept, 0);
        go(29);
        led_request = 1'b0;
        chk("leds2_only_b", leds, 18'h00004);
        go(31);
        chk("miss2_pulse", miss, 1);
        go(32);
        chk("leds_empty2", leds, 0);
        chk("misses3", misses, 3);
        // hit on the expiring tick (cycle 43) beats the timeout
        led_index = 4; led_request = 1'b1;
        #1 chk("acc4", req_accept, 1);
        go(33);
        led_request = 1'b0;
        chk("lit4", leds, 18'h00010);
        go(43);
        switches[4] = ~switches[4];
        led_request = 1'b1;
        #1 chk("hit4_tie", hit, 1);
        chk("miss4_tie", miss, 0);
        chk("rej4_same", req_accept, 0);
        go(44);
        chk("cleared4", leds, 0);
        chk("score2", score, 2);
        chk("misses3_hold", misses, 3);
        #1 chk("acc4_next", req_accept, 1);
        go(45);
        led_request = 1'b0;
        chk("relit4", leds, 18'h00010);
        // mid-game reset
        rst = 1'b1;
        go(46);
        chk("mid_rst_leds", leds, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_misses", misses, 0);
        rst = 1'b0;
        cyc_n = 0;
        // saturation with a 2-bit score
        led_index2 = 0; led_request2 = 1'b1;
        #1 chk("s_acc0", req_accept2, 1);
        go(1);
        led_index2 = 1;
        #1 chk("s_acc1", req_accept2, 1);
        go(2);
        led_request2 = 1'b0;
        chk("s_leds01", leds2, 18'h00003);
        switches2[1:0] = 2'b11;
        #1 chk("s_hit_dual", hit2, 1);
        go(3);
        chk("s_score2", score2, 2);
        chk("s_leds_empty", leds2, 0);
        chk("s_single_pulse", hit2, 0);
        led_index2 = 2; led_request2 = 1'b1;
        #1 chk("s_acc2", req_accept2, 1);
        go(4);
        led_request2 = 1'b0;
        switches2[2] = 1'b1;
        #1 chk("s_hit2", hit2, 1);
        go(5);
        chk("s_score3", score2, 3);
        led_index2 = 3; led_request2 = 1'b1;
        go(6);
        led_request2 = 1'b0;
        switches2[3] = 1'b1;
        #1 chk("s_hit3", hit2, 1);
        go(7);
        chk("s_sat_a", score2, 3);
        led_index2 = 4; led_request2 = 1'b1;
        go(8);
        led_request2 = 1'b0;
        switches2[4] = 1'b1;
        #1 chk("s_hit4", hit2, 1);
        go(9);
        chk("s_sat_b", score2, 3);
        chk("s_leds_end", leds2, 0);
        chk("s_misses", misses2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mole_target_ctrl.md
Name: mole_target_ctrl

Overview:
- Responder side of the RNG's led_index / led_request protocol.
- Accepts light-up requests, drives the target LEDs, and runs a per-LED lifetime timer.
- Detects player hits from board switch toggles and keeps the score plus a miss count.
- Sits between rng and score_display in the top level; drives LEDR and the score bus.

Parameters:
- NUM_LEDS, 18, number of target LEDs/switches (max 32).
- TICK_CYCLES, 50000, clk cycles per timer tick (1 ms at 50 MHz).
- ON_TICKS, 1000, LED lifetime in ticks (1..1023).
- MAX_ACTIVE, 4, max simultaneously lit LEDs (1..NUM_LEDS).
- SCORE_W, 12, width of score output.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- led_index  in  5  requested LED number
- led_request  in  1  single-cycle request strobe, sampled with led_index
- switches  in  NUM_LEDS  board switches, already synchronous to clk
- leds  out  NUM_LEDS  lit targets
- score  out  SCORE_W  hit count, binary
- misses  out  8  timeout count, binary
- req_accept  out  1  pulse: request accepted
- hit  out  1  pulse: at least one hit this cycle
- miss  out  1  pulse: at least one timeout this cycle

Behaviour:
- Reset (any cycle, including mid-game): leds, score, misses, req_accept, hit, miss = 0.
  - All timers and the prescaler are cleared.
  - sw_prev is loaded with the current switches, so no edge fires on the first post-reset cycle.
- Prescaler: free-running counter 0..TICK_CYCLES-1. tick = 1 on the cycle the count equals TICK_CYCLES-1; the count then wraps to 0.
- Switch edge: edge[i] = switches[i] XOR sw_prev[i]. Either direction counts. sw_prev updates every cycle.
- Request acceptance, all evaluated on the same cycle as led_request=1:
  - led_index < NUM_LEDS,
  - leds[led_index] = 0 (registered value),
  - active count (popcount of leds) < MAX_ACTIVE.
- On accept:
  - leds[led_index] = 1 and timer[led_index] = ON_TICKS, both from the next cycle.
  - req_accept = 1 for that one cycle.
- On reject: no state change and no pulse. Requests are not queued.
- Hit: leds[i]=1 and edge[i]=1.
  - Next cycle: leds[i]=0 and timer cleared.
  - score += number of hits that cycle, saturating at 2^SCORE_W-1.
  - hit pulses 1 cycle.
- Edge on an unlit LED: ignored, no penalty.
- Timeout: on a tick with leds[i]=1 and timer[i]=1, that LED clears next cycle.
  - misses += number of timeouts that cycle, saturating at 255.
  - miss pulses 1 cycle.
- Otherwise each tick decrements every nonzero timer.
- Resulting lifetime: between (ON_TICKS-1)*TICK_CYCLES+1 and ON_TICKS*TICK_CYCLES cycles.
- Same-cycle priority for the same LED: hit beats timeout; the LED scores and is not counted as a miss.
- Request for LED i on the same cycle LED i is hit or times out: rejected, because the registered leds[i] is still 1.
- Active-count check uses registered leds only. A slot freed this cycle is usable from the next cycle.
- Timer width: ceil(log2(ON_TICKS+1)) bits per LED. Score and misses never wrap.

Test Plan (TICK_CYCLES=4, ON_TICKS=3, MAX_ACTIVE=2 unless stated):
- Reset with switches=18'h3FFFF, then hold the switches -> no hit pulse. leds=0, score=0, misses=0 throughout.
- Request index 5, no switch activity -> req_accept on that cycle, leds=18'h00020 next cycle. LED clears after 9..12 cycles; miss pulse 1 cycle; misses=1, score=0.
- Request index 7, toggle SW[7] 3 cycles later -> leds[7] clears the next cycle, hit pulses once, score=1. A second SW[7] toggle -> no change.
- Requests for 1, then 2, then 3 while 1 and 2 are lit -> third rejected (no req_accept, leds=18'h00006). Request 1 again while lit -> rejected. Request index 20 -> rejected.
- LED 4 lit; toggle SW[4] on the same cycle as its expiring tick -> score +1, misses unchanged. A request for 4 on that same cycle is rejected; the same request one cycle later is accepted.
- SCORE_W=2: produce 5 hits, including 2 simultaneous switch toggles in one cycle -> score saturates at 3; the simultaneous hits produce a single hit pulse.
